// File: rtl/parity_checker_rx.sv
// Serial receiver for 8E1-style frames: start 0, 8 data LSB first, even parity, stop 1.
// Optional PARITY_ERR_CNT_EN builds a saturating errored-frame counter on err_count.
module parity_checker_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_sync1;
    logic          r_rx_s;
    logic          r_rx_s_d;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_perr;
    logic          r_ferr;

    logic w_fall;
    logic w_tick;
    logic w_load_half;
    logic w_load_full;
    logic w_shift;
    logic w_par_smp;
    logic w_done;
    logic w_perr;
    logic w_ferr;

    assign w_fall = r_rx_s_d & ~r_rx_s;
    assign w_tick = (r_cnt == C_ONE);
    assign w_perr = ^{r_shift, r_par};
    assign w_ferr = ~r_rx_s;

    // Synchroniser and edge-detect delay, all preset high so reset never fakes a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_rx_s   <= 1'b1;
            r_rx_s_d <= 1'b1;
        end else begin
            r_sync1  <= rx_in;
            r_rx_s   <= r_sync1;
            r_rx_s_d <= r_rx_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and datapath strobes; every sample happens on a counter tick
    always_comb begin
        w_next      = r_state;
        w_load_half = 1'b0;
        w_load_full = 1'b0;
        w_shift     = 1'b0;
        w_par_smp   = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_next      = S_START;
                    w_load_half = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_load_full = 1'b1;
                    w_next      = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift     = 1'b1;
                    w_load_full = 1'b1;
                    if (r_bit == 3'd7) w_next = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_par_smp   = 1'b1;
                    w_load_full = 1'b1;
                    w_next      = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Bit-period counter: reload on each sample, count down otherwise while framing
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_cnt <= '0;
        else if (w_load_half)     r_cnt <= C_HALF;
        else if (w_load_full)     r_cnt <= C_FULL;
        else if (r_state != S_IDLE) r_cnt <= r_cnt - C_ONE;
    end

    // Data/parity capture; bit index restarts whenever the start bit is confirmed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            if (r_state == S_START) r_bit <= '0;
            if (w_shift) begin
                r_shift[r_bit] <= r_rx_s;
                r_bit          <= r_bit + 3'd1;
            end
            if (w_par_smp) r_par <= r_rx_s;
        end
    end

    // Result registers, updated at the stop sample even for errored frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_done;
            if (w_done) begin
                r_data <= r_shift;
                r_perr <= w_perr;
                r_ferr <= w_ferr;
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of frames flagged with either error
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err_cnt <= '0;
        else if (w_done && (w_perr || w_ferr) && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 8'h00;
`endif

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/parity_checker_rx.md
# parity_checker_rx

Serial receiver and parity checker for 8-bit words protected by even parity, where the parity bit is the XOR of the 8 data bits. It deserialises a framed bit stream on a single line: start bit 0, 8 data bits LSB first, parity bit, stop bit 1. It presents each received byte with a one-cycle valid strobe and parity/framing error flags. It sits at the receive end of the board-to-board link, behind the pin and ahead of the consumer logic.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range 4..65535.
- `clk`  input  1  system clock, rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `rx_in`  input  1  serial line, asynchronous to `clk`; idles high.
- `rx_data`  output  8  last received byte; holds until the next frame completes.
- `rx_valid`  output  1  one-cycle pulse when a frame completes.
- `parity_err`  output  1  qualified by `rx_valid`; high when the XOR of the data bits and the parity bit is 1.
- `frame_err`  output  1  qualified by `rx_valid`; high when the stop bit is sampled 0.
- `busy`  output  1  high in every state except IDLE.
- `err_count`  output  8  saturating count of frames with `parity_err` or `frame_err` (see Configuration).

## Operation
- `rx_in` passes through a 2-flop synchroniser to give `rx_s`. `rx_s_d` is `rx_s` delayed by one flop.
  - All three flops reset to 1, so reset never creates a false edge.
- Start detection is a falling edge only: `rx_s_d`=1 and `rx_s`=0. A line held low (break) never retriggers.
- FSM states:
  - IDLE → START on a falling edge. The bit counter loads `H = CLKS_PER_BIT/2` (integer division).
  - START: at mid-bit, if `rx_s`=1 the start was a glitch and the FSM returns to IDLE with no strobe. Otherwise it goes to DATA and the counter reloads `CLKS_PER_BIT`.
  - DATA: takes 8 samples, one per bit period, shifting into bit `i` (LSB first). After the 8th sample it goes to PARITY.
  - PARITY: takes one sample and goes to STOP.
  - STOP: takes one sample, then:
    - registers `rx_data`, `parity_err = ^{data, parity}` and `frame_err = ~stop`;
    - pulses `rx_valid`;
    - returns directly to IDLE.
- A frame with errors still updates `rx_data` and still pulses `rx_valid`.
- Timing counter width is `$clog2(CLKS_PER_BIT+1)`.
  - A sample is taken when the counter reaches 1; the counter then reloads.
  - No other arithmetic is performed on the counter.

## Timing
- Let `k` be the first `clk` edge that samples `rx_in`=0. Edge detection registers at E = k+2.
- Sample points relative to E, with N = `CLKS_PER_BIT`:
  - start bit at E+H;
  - data bit i at E+H+(i+1)·N;
  - parity bit at E+H+9N;
  - stop bit at E+H+10N.
- `rx_valid`, `rx_data`, `parity_err` and `frame_err` are registered at the stop-sample edge, so they are visible in the following cycle.
  - `rx_valid` is high for exactly 1 cycle.
  - `parity_err` and `frame_err` hold their value until the next strobe.
- `busy` rises at E and falls at the stop-sample edge. A new falling edge is accepted from the next cycle onward.
- Reset values: `rx_data`=0x00, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, `err_count`=0, FSM=IDLE.
- Reset mid-frame aborts immediately with no strobe.
  - After release, a frame is recognised only on a fresh high→low transition of the line.
- Back-to-back frames with zero idle gap are received correctly.

## Configuration
- `PARITY_ERR_CNT_EN` defined:
  - `err_count` increments by 1 on each `rx_valid` with `parity_err` or `frame_err` set;
  - it saturates at 255 and clears only on `rst`.
- `PARITY_ERR_CNT_EN` undefined: no counter logic is built and `err_count` is tied to 8'h00.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Send 0xA5 with parity 0 and stop 1 → one `rx_valid` pulse, `rx_data`=0xA5, `parity_err`=0, `frame_err`=0, strobe at E+168.
- Send 0x07 with parity 0 (correct is 1) → `rx_data`=0x07, `parity_err`=1, `frame_err`=0. With the macro, `err_count`=1.
- Send 0x3C with parity 0 and stop 0, then hold the line low for 100 bit times → one strobe with `frame_err`=1, then no further strobes. Send 0x81 after the line returns high → received cleanly.
- Pulse `rx_in` low for 5 cycles → no `rx_valid`, `busy` returns to 0 at E+8.
- Assert `rst` during data bit 4 of a 0xFF frame → all outputs 0 at once. The next 0x12 frame decodes as 0x12 with no errors.
- With the macro, send 300 frames with bad parity → `err_count`=255. Without the macro, `err_count` stays 0.
